// File: rtl/axi_arb2.sv
// Two-master, one-slave arbiter for the simplified AXI bus: I-cache reads (m0) and
// D-cache reads/writes (m1) share one AXI port, one whole burst at a time, round-robin.
module axi_arb2 #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                m0_ar_valid,
    output logic                m0_ar_ready,
    input  logic [ADDR_W-1:0]   m0_ar_addr,
    input  logic [7:0]          m0_ar_len,
    output logic                m0_r_valid,
    output logic [DATA_W-1:0]   m0_r_data,
    output logic                m0_r_last,

    input  logic                m1_ar_valid,
    output logic                m1_ar_ready,
    input  logic [ADDR_W-1:0]   m1_ar_addr,
    input  logic [7:0]          m1_ar_len,
    output logic                m1_r_valid,
    output logic [DATA_W-1:0]   m1_r_data,
    output logic                m1_r_last,
    input  logic                m1_aw_valid,
    output logic                m1_aw_ready,
    input  logic [ADDR_W-1:0]   m1_aw_addr,
    input  logic                m1_w_valid,
    output logic                m1_w_ready,
    input  logic [DATA_W-1:0]   m1_w_data,
    input  logic [DATA_W/8-1:0] m1_w_strb,
    input  logic                m1_w_last,
    output logic                m1_b_valid,

    output logic                s_aw_valid,
    input  logic                s_aw_ready,
    output logic [ADDR_W-1:0]   s_aw_addr,
    output logic                s_w_valid,
    input  logic                s_w_ready,
    output logic [DATA_W-1:0]   s_w_data,
    output logic [DATA_W/8-1:0] s_w_strb,
    output logic                s_w_last,
    input  logic                s_b_valid,
    output logic                s_ar_valid,
    input  logic                s_ar_ready,
    output logic [ADDR_W-1:0]   s_ar_addr,
    output logic [7:0]          s_ar_len,
    input  logic                s_r_valid,
    input  logic [DATA_W-1:0]   s_r_data,
    input  logic                s_r_last,

    output logic                busy
);

    // state | meaning
    // IDLE  | no grant; all channel valids/readies held low
    // RD0   | master 0 read burst owns the slave
    // RD1   | master 1 read burst owns the slave
    // WR1   | master 1 write burst owns the slave
    typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

    state_t state;
    logic   last_gnt;
    logic   ar_done;
    logic   aw_done;
    logic   w_done;

    logic   p0;
    logic   p1;
    logic   rd0;
    logic   rd1;
    logic   wr1;

    assign p0  = m0_ar_valid;
    assign p1  = m1_aw_valid | m1_ar_valid;
    assign rd0 = (state == RD0);
    assign rd1 = (state == RD1);
    assign wr1 = (state == WR1);

    assign s_ar_valid  = ((rd0 & m0_ar_valid) | (rd1 & m1_ar_valid)) & ~ar_done;
    assign s_ar_addr   = rd1 ? m1_ar_addr : m0_ar_addr;
    assign s_ar_len    = rd1 ? m1_ar_len  : m0_ar_len;
    assign m0_ar_ready = rd0 & ~ar_done & s_ar_ready;
    assign m1_ar_ready = rd1 & ~ar_done & s_ar_ready;

    assign m0_r_valid  = rd0 & s_r_valid;
    assign m0_r_last   = rd0 & s_r_last;
    assign m0_r_data   = s_r_data;
    assign m1_r_valid  = rd1 & s_r_valid;
    assign m1_r_last   = rd1 & s_r_last;
    assign m1_r_data   = s_r_data;

    // w is gated off once its last beat is taken, so a stray extra beat never leaks.
    assign s_aw_valid  = wr1 & m1_aw_valid & ~aw_done;
    assign s_aw_addr   = m1_aw_addr;
    assign m1_aw_ready = wr1 & ~aw_done & s_aw_ready;
    assign s_w_valid   = wr1 & m1_w_valid & ~w_done;
    assign s_w_data    = m1_w_data;
    assign s_w_strb    = m1_w_strb;
    assign s_w_last    = m1_w_last;
    assign m1_w_ready  = wr1 & ~w_done & s_w_ready;
    assign m1_b_valid  = wr1 & s_b_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            ar_done  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ar_done <= 1'b0;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (p0 && (!p1 || last_gnt)) begin
                        state    <= RD0;
                        last_gnt <= 1'b0;
                        busy     <= 1'b1;
                    end else if (p1) begin
                        state    <= m1_aw_valid ? WR1 : RD1;
                        last_gnt <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RD0, RD1: begin
                    if (s_ar_valid && s_ar_ready)
                        ar_done <= 1'b1;
                    if (s_r_valid && s_r_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                WR1: begin
                    if (s_aw_valid && s_aw_ready)
                        aw_done <= 1'b1;
                    if (s_w_valid && s_w_ready && s_w_last)
                        w_done <= 1'b1;
                    if (s_b_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_arb2.sv
// Directed bench for axi_arb2: linear stimulus drives both masters and a scripted slave;
// read beats are queued as expectations and checked when they reach a master.
module tb_axi_arb2;

    logic        clock = 1'b0;
    logic        reset;

    logic        m0_ar_valid, m0_ar_ready;
    logic [63:0] m0_ar_addr;
    logic [7:0]  m0_ar_len;
    logic        m0_r_valid, m0_r_last;
    logic [63:0] m0_r_data;

    logic        m1_ar_valid, m1_ar_ready;
    logic [63:0] m1_ar_addr;
    logic [7:0]  m1_ar_len;
    logic        m1_r_valid, m1_r_last;
    logic [63:0] m1_r_data;
    logic        m1_aw_valid, m1_aw_ready;
    logic [63:0] m1_aw_addr;
    logic        m1_w_valid, m1_w_ready, m1_w_last;
    logic [63:0] m1_w_data;
    logic [7:0]  m1_w_strb;
    logic        m1_b_valid;

    logic        s_aw_valid, s_aw_ready;
    logic [63:0] s_aw_addr;
    logic        s_w_valid, s_w_ready, s_w_last;
    logic [63:0] s_w_data;
    logic [7:0]  s_w_strb;
    logic        s_b_valid;
    logic        s_ar_valid, s_ar_ready;
    logic [63:0] s_ar_addr;
    logic [7:0]  s_ar_len;
    logic        s_r_valid, s_r_last;
    logic [63:0] s_r_data;
    logic        busy;

    typedef struct {
        logic        id;
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;
    int    b_cnt = 0;

    always #5 clock = ~clock;

    axi_arb2 dut (
        .clock(clock), .reset(reset),
        .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr),
        .m0_ar_len(m0_ar_len), .m0_r_valid(m0_r_valid), .m0_r_data(m0_r_data),
        .m0_r_last(m0_r_last),
        .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr),
        .m1_ar_len(m1_ar_len), .m1_r_valid(m1_r_valid), .m1_r_data(m1_r_data),
        .m1_r_last(m1_r_last),
        .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready), .m1_aw_addr(m1_aw_addr),
        .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready), .m1_w_data(m1_w_data),
        .m1_w_strb(m1_w_strb), .m1_w_last(m1_w_last), .m1_b_valid(m1_b_valid),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
        .s_w_strb(s_w_strb), .s_w_last(s_w_last), .s_b_valid(s_b_valid),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_ar_len(s_ar_len), .s_r_valid(s_r_valid), .s_r_data(s_r_data),
        .s_r_last(s_r_last), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check1(input string name, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic send_beat(input logic id, input logic [63:0] d, input logic l);
        beat_t e;
        s_r_valid = 1'b1;
        s_r_data  = d;
        s_r_last  = l;
        e.id = id;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    // Scoreboard side: every beat seen at a master must match the oldest queued beat.
    always @(negedge clock) begin
        beat_t e;
        if (m1_b_valid)
            b_cnt++;
        if (m0_r_valid || m1_r_valid) begin
            check1("r_beat_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check1("r_valid_m0", m0_r_valid, !e.id);
                check1("r_valid_m1", m1_r_valid, e.id);
                check("r_data", e.id ? m1_r_data : m0_r_data, e.data);
                check1("r_last", e.id ? m1_r_last : m0_r_last, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        m0_ar_valid = 1'b1; m0_ar_addr = '0; m0_ar_len = '0;
        m1_ar_valid = 1'b0; m1_ar_addr = '0; m1_ar_len = '0;
        m1_aw_valid = 1'b0; m1_aw_addr = '0;
        m1_w_valid = 1'b0; m1_w_data = '0; m1_w_strb = '0; m1_w_last = 1'b0;
        s_aw_ready = 1'b1; s_w_ready = 1'b1; s_b_valid = 1'b0;
        s_ar_ready = 1'b1; s_r_valid = 1'b0; s_r_data = '0; s_r_last = 1'b0;

        // reset state
        smp();
        check1("rst_busy", busy, 1'b0);
        check1("rst_s_ar_valid", s_ar_valid, 1'b0);
        check1("rst_m0_ar_ready", m0_ar_ready, 1'b0);
        check1("rst_s_aw_valid", s_aw_valid, 1'b0);
        cyc();
        reset = 1'b0;
        m0_ar_valid = 1'b0;
        s_aw_ready = 1'b0;
        s_w_ready = 1'b0;

        // master 0 single read
        m0_ar_valid = 1'b1; m0_ar_addr = 64'h8000_0000; m0_ar_len = 8'd0;
        smp();
        check1("t1_idle_no_ar", s_ar_valid, 1'b0);
        check1("t1_idle_busy", busy, 1'b0);
        cyc(); smp();
        check1("t1_ar_valid", s_ar_valid, 1'b1);
        check("t1_ar_addr", s_ar_addr, 64'h8000_0000);
        check("t1_ar_len", 64'(s_ar_len), 64'd0);
        check1("t1_m0_ar_ready", m0_ar_ready, 1'b1);
        check1("t1_m1_ar_ready", m1_ar_ready, 1'b0);
        check1("t1_busy", busy, 1'b1);
        cyc();
        m0_ar_valid = 1'b0;
        send_beat(1'b0, 64'h1122_3344_5566_7788, 1'b1);
        smp();
        check1("t1_r_valid", m0_r_valid, 1'b1);
        check1("t1_ar_off", s_ar_valid, 1'b0);
        cyc();
        s_r_valid = 1'b0; s_r_last = 1'b0;
        smp();
        check1("t1_idle_after", busy, 1'b0);
        check1("t1_r_valid_off", m0_r_valid, 1'b0);

        // master 1 burst of 4
        m1_ar_valid = 1'b1; m1_ar_addr = 64'h8000_0100; m1_ar_len = 8'd3;
        cyc(); smp();
        check1("t2_ar_valid", s_ar_valid, 1'b1);
        check("t2_ar_addr", s_ar_addr, 64'h8000_0100);
        check("t2_ar_len", 64'(s_ar_len), 64'd3);
        check1("t2_m1_ar_ready", m1_ar_ready, 1'b1);
        check1("t2_m0_ar_ready", m0_ar_ready, 1'b0);
        cyc(); smp();
        check1("t2_ar_once", s_ar_valid, 1'b0);
        check1("t2_ar_ready_once", m1_ar_ready, 1'b0);
        cyc();
        m1_ar_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_beat(1'b1, 64'hA000 + 64'(i), (i == 3));
            smp();
            check1("t2_m0_quiet", m0_r_valid, 1'b0);
            check1("t2_busy", busy, 1'b1);
            cyc();
        end
        s_r_valid = 1'b0; s_r_last = 1'b0;
        smp();
        check1("t2_idle_after", busy, 1'b0);

        // tie and round-robin, starting from reset
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        m0_ar_valid = 1'b1; m0_ar_addr = 64'h8000_2000; m0_ar_len = 8'd0;
        m1_ar_valid = 1'b1; m1_ar_addr = 64'h8000_3000; m1_ar_len = 8'd0;
        for (int k = 0; k < 4; k++) begin
            logic exp_id;
            exp_id = (k % 2) != 0;
            cyc(); smp();
            check("t3_grant_addr", s_ar_addr, exp_id ? 64'h8000_3000 : 64'h8000_2000);
            check1("t3_m0_ready", m0_ar_ready, !exp_id);
            check1("t3_m1_ready", m1_ar_ready, exp_id);
            cyc();
            send_beat(exp_id, 64'h3000 + 64'(k), 1'b1);
            smp();
            check1("t3_ar_off", s_ar_valid, 1'b0);
            cyc();
            s_r_valid = 1'b0; s_r_last = 1'b0;
            smp();
            check1("t3_bubble", busy, 1'b0);
            check1("t3_bubble_ar", s_ar_valid, 1'b0);
        end
        m0_ar_valid = 1'b0;
        m1_ar_valid = 1'b0;

        // write with w leading aw by two cycles
        m1_w_valid = 1'b1; m1_w_data = 64'hDEAD_BEEF; m1_w_strb = 8'h0F; m1_w_last = 1'b1;
        s_w_ready = 1'b1; s_aw_ready = 1'b0;
        smp();
        check1("t4_idle_no_w", s_w_valid, 1'b0);
        check1("t4_idle_no_wready", m1_w_ready, 1'b0);
        cyc(); cyc();
        m1_aw_valid = 1'b1; m1_aw_addr = 64'h8000_1000;
        smp();
        check1("t4_idle_no_aw", s_aw_valid, 1'b0);
        cyc();
        m0_ar_valid = 1'b1; m0_ar_addr = 64'h8000_4000; m0_ar_len = 8'd0;
        smp();
        check1("t4_w_valid", s_w_valid, 1'b1);
        check("t4_w_data", s_w_data, 64'hDEAD_BEEF);
        check("t4_w_strb", 64'(s_w_strb), 64'h0F);
        check1("t4_w_last", s_w_last, 1'b1);
        check1("t4_w_ready", m1_w_ready, 1'b1);
        check1("t4_aw_valid", s_aw_valid, 1'b1);
        check("t4_aw_addr", s_aw_addr, 64'h8000_1000);
        check1("t4_aw_wait", m1_aw_ready, 1'b0);
        check1("t4_m0_blocked", m0_ar_ready, 1'b0);
        check1("t4_no_ar", s_ar_valid, 1'b0);
        cyc();
        m1_w_valid = 1'b0;
        s_aw_ready = 1'b1;
        smp();
        check1("t4_w_done", s_w_valid, 1'b0);
        check1("t4_aw_ready", m1_aw_ready, 1'b1);
        cyc();
        m1_aw_valid = 1'b0;
        s_b_valid = 1'b1;
        smp();
        check1("t4_aw_once", s_aw_valid, 1'b0);
        check1("t4_b_valid", m1_b_valid, 1'b1);
        check1("t4_m0_blocked_b", m0_ar_ready, 1'b0);
        cyc();
        s_b_valid = 1'b0;
        smp();
        check1("t4_idle_after", busy, 1'b0);
        check1("t4_b_off", m1_b_valid, 1'b0);
        check1("t4_idle_no_ar", s_ar_valid, 1'b0);
        cyc(); smp();
        check1("t4_m0_grant", s_ar_valid, 1'b1);
        check("t4_m0_addr", s_ar_addr, 64'h8000_4000);
        cyc();
        m0_ar_valid = 1'b0;
        send_beat(1'b0, 64'h4444, 1'b1);
        cyc();
        s_r_valid = 1'b0; s_r_last = 1'b0;
        smp();
        check("t4_b_count", 64'(b_cnt), 64'd1);

        // write and read from master 1 together: write first
        m1_aw_valid = 1'b1; m1_aw_addr = 64'h8000_5000;
        m1_ar_valid = 1'b1; m1_ar_addr = 64'h8000_6000; m1_ar_len = 8'd0;
        m1_w_valid = 1'b1; m1_w_data = 64'h55; m1_w_strb = 8'hFF; m1_w_last = 1'b1;
        cyc(); smp();
        check1("t5_aw_first", s_aw_valid, 1'b1);
        check("t5_aw_addr", s_aw_addr, 64'h8000_5000);
        check1("t5_no_ar", s_ar_valid, 1'b0);
        check1("t5_no_ar_ready", m1_ar_ready, 1'b0);
        check1("t5_aw_ready", m1_aw_ready, 1'b1);
        cyc();
        m1_aw_valid = 1'b0;
        m1_w_valid = 1'b0;
        s_b_valid = 1'b1;
        smp();
        check1("t5_b_valid", m1_b_valid, 1'b1);
        cyc();
        s_b_valid = 1'b0;
        smp();
        check1("t5_bubble", busy, 1'b0);
        cyc(); smp();
        check1("t5_rd_grant", s_ar_valid, 1'b1);
        check("t5_rd_addr", s_ar_addr, 64'h8000_6000);
        check1("t5_rd_ready", m1_ar_ready, 1'b1);
        cyc();
        m1_ar_valid = 1'b0;
        send_beat(1'b1, 64'h6666, 1'b1);
        cyc();
        s_r_valid = 1'b0; s_r_last = 1'b0;
        smp();
        check("t5_b_count", 64'(b_cnt), 64'd2);

        // reset during the second beat of a 4-beat read
        m0_ar_valid = 1'b1; m0_ar_addr = 64'h8000_7000; m0_ar_len = 8'd3;
        cyc(); smp();
        check1("t6_grant", s_ar_valid, 1'b1);
        cyc();
        m0_ar_valid = 1'b0;
        send_beat(1'b0, 64'h7000, 1'b0);
        cyc();
        s_r_valid = 1'b1; s_r_data = 64'h7001; s_r_last = 1'b0;
        reset = 1'b1;
        smp();
        check1("t6_r_valid", m0_r_valid, 1'b0);
        check1("t6_r_valid_m1", m1_r_valid, 1'b0);
        check1("t6_busy", busy, 1'b0);
        check1("t6_ar_valid", s_ar_valid, 1'b0);
        check1("t6_aw_valid", s_aw_valid, 1'b0);
        cyc();
        s_r_valid = 1'b0;
        reset = 1'b0;
        m0_ar_valid = 1'b1; m0_ar_addr = 64'h8000_8000; m0_ar_len = 8'd0;
        cyc(); smp();
        check1("t6_new_grant", s_ar_valid, 1'b1);
        check("t6_new_addr", s_ar_addr, 64'h8000_8000);
        check1("t6_new_ready", m0_ar_ready, 1'b1);
        cyc();
        m0_ar_valid = 1'b0;
        send_beat(1'b0, 64'h8888, 1'b1);
        smp();
        check1("t6_new_r_valid", m0_r_valid, 1'b1);
        cyc();
        s_r_valid = 1'b0; s_r_last = 1'b0;
        smp();
        check1("t6_idle_after", busy, 1'b0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
